// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for the 1-bit ALU slice: latches operands, walks them LSB first
// through the slice while chaining the carry, then assembles the result and C/Z/O/S flags.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opsel,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             z_flag,
    output logic             o_flag,
    output logic             s_flag,
    output logic             bit_op1,
    output logic             bit_op2,
    output logic [2:0]       bit_opsel,
    output logic             bit_mode,
    output logic             bit_cin,
    input  logic             bit_result,
    input  logic             bit_cout,
    output logic [1:0]       state_dbg
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       opsel_q, opsel_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_q, c_d, z_q, z_d, o_q, o_d, s_q, s_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             run;
    logic             arith;
    logic             res_bit;
    logic [WIDTH-1:0] res_upd;

    // Request handshake: start is a level sampled on every rising edge; it is accepted
    // only in IDLE or DONE (no ready output), and ignored without queuing while in RUN.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        opsel_d  = opsel_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        o_d      = o_q;
        s_d      = s_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        arith   = (opsel_q == OP_ADD) || (opsel_q == OP_SUB);
        res_bit = (opsel_q == OP_RSVD) ? 1'b0 : bit_result;
        res_upd = result_q;
        res_upd[idx_q] = res_bit;

        case (state_q)
            S_RUN: begin
                result_d = res_upd;
                carry_d  = bit_cout;
                if (idx_q == IW'(WIDTH - 1)) begin
                    // carry_q is still the carry into the MSB here, bit_cout the carry out
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    c_d     = arith & bit_cout;
                    o_d     = mode_q & arith & (carry_q ^ bit_cout);
                    z_d     = ~|res_upd;
                    s_d     = res_upd[WIDTH-1];
                end else begin
                    busy_d = 1'b1;
                    idx_d  = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                    a_d      = a;
                    b_d      = b;
                    opsel_d  = opsel;
                    mode_d   = mode;
                    idx_d    = '0;
                    carry_d  = (opsel == OP_SUB);
                    result_d = '0;
                    c_d      = 1'b0;
                    z_d      = 1'b0;
                    o_d      = 1'b0;
                    s_d      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opsel_q  <= '0;
            mode_q   <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            o_q      <= 1'b0;
            s_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opsel_q  <= opsel_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            o_q      <= o_d;
            s_q      <= s_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Slice inputs are only driven while walking the bits; quiet zero otherwise.
    assign run       = (state_q == S_RUN);
    assign bit_op1   = run & a_q[idx_q];
    assign bit_op2   = run & b_q[idx_q];
    assign bit_opsel = run ? opsel_q : 3'b000;
    assign bit_mode  = run & mode_q;
    assign bit_cin   = run & carry_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign c_flag    = c_q;
    assign z_flag    = z_q;
    assign o_flag    = o_q;
    assign s_flag    = s_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (WIDTH=8) with a behavioural 1-bit ALU slice model.
module tb_alu_serial_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic [2:0] opsel;
    logic       mode;
    logic       busy, done;
    logic [7:0] result;
    logic       c_flag, z_flag, o_flag, s_flag;
    logic       bit_op1, bit_op2, bit_mode, bit_cin, bit_result, bit_cout;
    logic [2:0] bit_opsel;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int cycles;
    int done_cnt;

    alu_serial_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .opsel(opsel), .mode(mode),
        .busy(busy), .done(done), .result(result),
        .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .s_flag(s_flag),
        .bit_op1(bit_op1), .bit_op2(bit_op2), .bit_opsel(bit_opsel), .bit_mode(bit_mode),
        .bit_cin(bit_cin), .bit_result(bit_result), .bit_cout(bit_cout),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slice: SUB inverts op2, arithmetic is a full adder, logic ops carry 0.
    logic op2e;
    always_comb begin
        op2e       = bit_op2 ^ (bit_opsel == 3'b001);
        bit_result = 1'b0;
        bit_cout   = 1'b0;
        case (bit_opsel)
            3'b000, 3'b001: begin
                bit_result = bit_op1 ^ op2e ^ bit_cin;
                bit_cout   = (bit_op1 & op2e) | (bit_op1 & bit_cin) | (op2e & bit_cin);
            end
            3'b010:  bit_result = bit_op1 & bit_op2;
            3'b011:  bit_result = bit_op1 | bit_op2;
            3'b100:  bit_result = bit_op1 ^ bit_op2;
            3'b101:  bit_result = ~bit_op1;
            3'b110:  bit_result = bit_op2;
            default: bit_result = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [2:0] op, input logic m, input logic [7:0] er,
                          input logic ec, input logic ez, input logic eo, input logic es);
        a = ta; b = tb_v; opsel = op; mode = m; start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        chk({tag, "_state_run"}, {30'd0, state_dbg}, 32'd1);
        chk({tag, "_res_clr"}, {24'd0, result}, 32'd0);
        chk({tag, "_flags_clr"}, {28'd0, c_flag, z_flag, o_flag, s_flag}, 32'd0);
        chk({tag, "_cin0"}, {31'd0, bit_cin}, {31'd0, (op == 3'b001)});
        chk({tag, "_op1_0"}, {31'd0, bit_op1}, {31'd0, ta[0]});
        chk({tag, "_op2_0"}, {31'd0, bit_op2}, {31'd0, tb_v[0]});
        chk({tag, "_opsel"}, {29'd0, bit_opsel}, {29'd0, op});
        // latched operands must not follow the ports during RUN
        a = ~ta; b = ~tb_v; opsel = ~op; mode = ~m;
        wait_done();
        chk({tag, "_latency"}, cycles, 32'd9);
        chk({tag, "_result"}, {24'd0, result}, {24'd0, er});
        chk({tag, "_flags_czos"}, {28'd0, c_flag, z_flag, o_flag, s_flag}, {28'd0, ec, ez, eo, es});
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {30'd0, state_dbg}, 32'd0);
        chk({tag, "_res_hold"}, {24'd0, result}, {24'd0, er});
        chk({tag, "_flags_hold"}, {28'd0, c_flag, z_flag, o_flag, s_flag}, {28'd0, ec, ez, eo, es});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; opsel = '0; mode = 1'b0;
        #12;
        chk("rst_outputs", {22'd0, busy, done, c_flag, z_flag, o_flag, s_flag, bit_op1, bit_op2,
                            bit_mode, bit_cin}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_state", {27'd0, bit_opsel, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        //            tag   a      b      op      mode  result c  z  o  s
        run_op("add_ovf",   8'h7F, 8'h01, 3'b000, 1'b1, 8'h80, 0, 0, 1, 1);
        run_op("sub_eq",    8'h05, 8'h05, 3'b001, 1'b1, 8'h00, 1, 1, 0, 0);
        run_op("add_wrap",  8'hFF, 8'h01, 3'b000, 1'b0, 8'h00, 1, 1, 0, 0);
        run_op("and",       8'hF0, 8'h3C, 3'b010, 1'b1, 8'h30, 0, 0, 0, 0);
        run_op("sub_ovf",   8'h80, 8'h01, 3'b001, 1'b1, 8'h7F, 1, 0, 1, 0);
        run_op("add_uns",   8'h7F, 8'h01, 3'b000, 1'b0, 8'h80, 0, 0, 0, 1);
        run_op("or",        8'hA0, 8'h05, 3'b011, 1'b1, 8'hA5, 0, 0, 0, 1);
        run_op("not_a",     8'h0F, 8'hAA, 3'b101, 1'b1, 8'hF0, 0, 0, 0, 1);
        run_op("pass_b",    8'hFF, 8'h00, 3'b110, 1'b1, 8'h00, 0, 1, 0, 0);
        run_op("rsvd",      8'hFF, 8'hFF, 3'b111, 1'b1, 8'h00, 0, 1, 0, 0);

        // start held through RUN, then back-to-back accept in the DONE cycle
        a = 8'h12; b = 8'h34; opsel = 3'b000; mode = 1'b0; start = 1'b1;
        tick();
        a = 8'hFF; b = 8'hFF; opsel = 3'b001;
        done_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        chk("hold_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        tick();
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_single", done_cnt, 32'd0);
        chk("hold_result", {24'd0, result}, 32'h46);
        a = 8'hA5; b = 8'hFF; opsel = 3'b100; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_no_done", {31'd0, done}, 32'd0);
        wait_done();
        chk("b2b_latency", cycles, 32'd9);
        chk("b2b_result", {24'd0, result}, 32'h5A);
        chk("b2b_flags", {28'd0, c_flag, z_flag, o_flag, s_flag}, 32'd0);
        tick();

        // reset in RUN cycle 4
        a = 8'h0F; b = 8'h01; opsel = 3'b000; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {26'd0, busy, done, state_dbg, bit_op1, bit_cin}, 32'd0);
        chk("mid_rst_res", {24'd0, result}, 32'd0);
        chk("mid_rst_flags", {28'd0, c_flag, z_flag, o_flag, s_flag}, 32'd0);
        #2;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        chk("mid_no_done", done_cnt, 32'd0);
        run_op("post_rst",  8'h03, 8'h05, 3'b001, 1'b1, 8'hFE, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
